// File: rtl/psw_conditioner.sv
// Push-button conditioner: 2-flop sync + stable-level debounce + one-cycle press pulse, 4 channels.
// Latency: o_psw_lvl/o_psw_push change DEB_CYCLES+2 edges after a stable raw level is first sampled.
// Backpressure: none; o_psw_push is a free-running pulse that consumers must sample every cycle.
//
// Ports:
//   i_clock     system clock, all state on the rising edge
//   i_reset_n   asynchronous active-low reset, clears every flop
//   i_psw[3:0]  raw asynchronous buttons, 1 = pressed (bit 0 left, bit 3 right)
//   o_psw_lvl   debounced level per channel, 1 = held
//   o_psw_push  one-cycle pulse per accepted press (plus auto-repeats when enabled)
//
// Optional feature: define PSW_AUTOREPEAT_EN to add per-channel auto-repeat pulses
// (first after REP_DELAY cycles, then every REP_PERIOD cycles while held).
module psw_conditioner #(
  parameter int DEB_CYCLES = 20000,
  parameter int REP_DELAY  = 500000,
  parameter int REP_PERIOD = 100000
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic [3:0] i_psw,
  output logic [3:0] o_psw_lvl,
  output logic [3:0] o_psw_push
);

  localparam int DCW = ($clog2(DEB_CYCLES) < 1) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

  // Elaboration-time guard on the legal parameter ranges.
  if (DEB_CYCLES < 2 || REP_PERIOD < 2 || REP_DELAY < 1) begin : g_param_bad
    $error("psw_conditioner: DEB_CYCLES and REP_PERIOD must be >= 2, REP_DELAY >= 1");
  end

  logic [3:0] r_s1;
  logic [3:0] r_s2;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1 <= 4'b0;
      r_s2 <= 4'b0;
    end else begin
      r_s1 <= i_psw;
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch
    logic [DCW-1:0] r_deb_cnt;
    logic           r_lvl;
    logic           r_push;
    logic           w_diff;
    logic           w_fire;
    logic           w_press;

    assign w_diff  = r_s2[g] ^ r_lvl;
    // Level flips on the edge where the differing run reaches DEB_CYCLES samples.
    assign w_fire  = w_diff && (r_deb_cnt == DEB_LAST);
    assign w_press = w_fire && r_s2[g];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_deb_cnt <= '0;
        r_lvl     <= 1'b0;
      end else if (!w_diff) begin
        r_deb_cnt <= '0;
      end else if (w_fire) begin
        r_deb_cnt <= '0;
        r_lvl     <= r_s2[g];
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end

`ifdef PSW_AUTOREPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REP_PERIOD - 1);

    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_phase;  // 0: waiting for first repeat, 1: periodic repeats
    logic          w_hold;
    logic          w_rep_hit;

    // Held means the level is 1 and is not falling on this edge, so a release
    // edge can never carry a repeat pulse.
    assign w_hold    = r_lvl && !w_fire;
    assign w_rep_hit = w_hold && (r_rep_phase ? (r_rep_cnt == PER_LAST)
                                              : (r_rep_cnt == DLY_LAST));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b0;
      end else if (!w_hold) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b0;
      end else if (w_rep_hit) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b1;
      end else begin
        r_rep_cnt   <= r_rep_cnt + 1'b1;
      end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) r_push <= 1'b0;
      else            r_push <= w_press || w_rep_hit;
    end
`else
    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) r_push <= 1'b0;
      else            r_push <= w_press;
    end
`endif

    assign o_psw_lvl[g]  = r_lvl;
    assign o_psw_push[g] = r_push;
  end

endmodule

// File: tb/tb_psw_conditioner.sv
// Directed bench for psw_conditioner with a pulse scoreboard.
// Expected pulses are queued with the cycle they must appear in; a negedge monitor pops and compares.
// No handshake; every wait is a fixed cycle count so the run always ends.
module tb_psw_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] psw;
  logic [3:0] psw_lvl;
  logic [3:0] psw_push;

  int edge_cnt = 0;
  int checks   = 0;
  int errors   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];

  psw_conditioner #(
    .DEB_CYCLES(4),
    .REP_DELAY (10),
    .REP_PERIOD(3)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_psw     (psw),
    .o_psw_lvl (psw_lvl),
    .o_psw_push(psw_push)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Pulse monitor: edge_cnt at a negedge is the edge after which the pulse is high.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc == edge_cnt) begin
      e = sb.pop_front();
      checks++;
      assert (psw_push === e.val) else begin
        errors++;
        $error("FAIL push_at_cycle_%0d observed=%b expected=%b", e.cyc, psw_push, e.val);
      end
    end else if (psw_push !== 4'b0000) begin
      checks++;
      assert (psw_push === 4'b0000) else begin
        errors++;
        $error("FAIL unexpected_push cycle=%0d observed=%b expected=0000", edge_cnt, psw_push);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input int cyc, input logic [3:0] v);
    exp_t e;
    e.cyc = cyc;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  initial begin
    int t0;
    int t1;
    int e0;

    // Reset with all buttons held.
    rst_n = 1'b0;
    psw   = 4'b1111;
    tick(3);
    chk("reset_lvl", psw_lvl, 4'b0000);
    chk("reset_push", psw_push, 4'b0000);
    t0 = edge_cnt;
    rst_n = 1'b1;
    expect_push(t0 + 6, 4'b1111);
    tick(5);
    chk("held_reset_lvl_pre", psw_lvl, 4'b0000);
    tick(1);
    chk("held_reset_lvl", psw_lvl, 4'b1111);
    chk("held_reset_push", psw_push, 4'b1111);
    tick(1);
    chk("held_reset_push_end", psw_push, 4'b0000);
    psw = 4'b0000;
    tick(8);
    chk("all_released_lvl", psw_lvl, 4'b0000);

    // Bounce on channel 0: 3 high, 1 low, five times.
    for (int i = 0; i < 5; i++) begin
      psw[0] = 1'b1;
      tick(3);
      psw[0] = 1'b0;
      tick(1);
    end
    tick(2);
    chk("bounce_lvl", psw_lvl, 4'b0000);
    t0 = edge_cnt;
    psw[0] = 1'b1;
    expect_push(t0 + 6, 4'b0001);
    tick(6);
    chk("bounce_then_hold_lvl", psw_lvl, 4'b0001);
    tick(2);
    psw[0] = 1'b0;
    tick(8);
    chk("bounce_release_lvl", psw_lvl, 4'b0000);

    // Release on channel 2: level falls 6 edges after raw fall, no pulse.
    t0 = edge_cnt;
    psw[2] = 1'b1;
    expect_push(t0 + 6, 4'b0100);
    tick(8);
    psw[2] = 1'b0;
    tick(5);
    chk("release_lvl_pre", psw_lvl, 4'b0100);
    tick(1);
    chk("release_lvl_fall", psw_lvl, 4'b0000);
    chk("release_no_push", psw_push, 4'b0000);
    tick(4);

    // Concurrency: channel 1 two cycles after channel 0.
    t0 = edge_cnt;
    psw[0] = 1'b1;
    expect_push(t0 + 6, 4'b0001);
    expect_push(t0 + 8, 4'b0010);
    tick(2);
    psw[1] = 1'b1;
    tick(8);
    chk("concurrent_lvl", psw_lvl, 4'b0011);
    psw[1:0] = 2'b00;
    tick(8);
    chk("concurrent_release_lvl", psw_lvl, 4'b0000);

    // Channel 3 held 25 cycles after its pulse.
    t0 = edge_cnt;
    e0 = t0 + 6;
    psw[3] = 1'b1;
    expect_push(e0, 4'b1000);
`ifdef PSW_AUTOREPEAT_EN
    for (int k = 0; k < 6; k++) expect_push(e0 + 10 + 3 * k, 4'b1000);
`endif
    tick(26);
    psw[3] = 1'b0;  // level falls at e0+26, before the next repeat slot
    tick(25);
    chk("repeat_long_lvl", psw_lvl, 4'b0000);

    // Channel 3 released so the level falls at +14.
    t0 = edge_cnt;
    e0 = t0 + 6;
    psw[3] = 1'b1;
    expect_push(e0, 4'b1000);
`ifdef PSW_AUTOREPEAT_EN
    expect_push(e0 + 10, 4'b1000);
    expect_push(e0 + 13, 4'b1000);
`endif
    tick(14);
    psw[3] = 1'b0;
    tick(6);
    chk("repeat_short_lvl", psw_lvl, 4'b0000);
    tick(10);

    // Reset pulse mid-debounce with channel 1 still held.
    t0 = edge_cnt;
    psw[1] = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_lvl", psw_lvl, 4'b0000);
    chk("mid_reset_push", psw_push, 4'b0000);
    tick(1);
    t1 = edge_cnt;
    rst_n = 1'b1;
    expect_push(t1 + 6, 4'b0010);
    tick(5);
    chk("post_reset_lvl_pre", psw_lvl, 4'b0000);
    tick(1);
    chk("post_reset_lvl", psw_lvl, 4'b0010);
    tick(2);
    psw[1] = 1'b0;
    tick(10);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL missing_pushes observed=%0d expected=0 (first at cycle %0d)", sb.size(), sb[0].cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
